// File: rtl/cache_assoc_if.sv
// Request/response bus of the set-associative cache.
// The master issues lookups; the slave (the cache) returns one-cycle response pulses.
interface cache_assoc_if #(
    parameter int DATAWIDTH = 64,
    parameter int ADDRWIDTH = 32
);
    localparam int BSEL = DATAWIDTH / 8;

    logic                 req_valid;
    logic                 req_ready;
    logic [ADDRWIDTH-1:0] req_addr;
    logic                 req_we;
    logic [BSEL-1:0]      req_bsel;
    logic [DATAWIDTH-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_hit;
    logic [DATAWIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_bsel, req_wdata,
        input  req_ready, rsp_valid, rsp_hit, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_bsel, req_wdata,
        output req_ready, rsp_valid, rsp_hit, rsp_rdata
    );
endinterface

// File: rtl/cache_assoc.sv
// N-way set-associative, write-through, no-write-allocate cache.
// Per-way byte-lane data RAM and tag RAM with registered reads, valid bits in
// flops, lowest-invalid-way / per-set round-robin victim choice and a
// single-word refill handshake towards external memory.
module cache_assoc #(
    parameter int DATAWIDTH = 64,
    parameter int SETS      = 256,
    parameter int WAYS      = 2,
    parameter int ADDRWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_assoc_if.slave         bus,
    output logic                 refill_req,
    output logic [ADDRWIDTH-1:0] refill_addr,
    input  logic                 refill_valid,
    input  logic [DATAWIDTH-1:0] refill_data,
    input  logic                 flush
);
    localparam int BSEL = DATAWIDTH / 8;
    localparam int OFFW = (BSEL > 1) ? $clog2(BSEL) : 0;
    localparam int IDXW = $clog2(SETS);
    localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAGW = ADDRWIDTH - IDXW - OFFW;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t               state_q, state_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic                 we_q, we_d;
    logic [BSEL-1:0]      bsel_q, bsel_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic [WAYW-1:0]      victim_q, victim_d;
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      valid_d [SETS];
    logic [WAYW-1:0]      rr_q [SETS];
    logic [WAYW-1:0]      rr_d [SETS];
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_hit_q, rsp_hit_d;
    logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 refill_req_q, refill_req_d;
    logic [ADDRWIDTH-1:0] refill_addr_q, refill_addr_d;

    // Address fields of the captured request and of the incoming request
    logic [IDXW-1:0] cur_idx;
    logic [TAGW-1:0] cur_tag;
    logic [IDXW-1:0] req_idx;
    logic            accept;

    assign cur_idx = addr_q[OFFW +: IDXW];
    assign cur_tag = addr_q[ADDRWIDTH-1 -: TAGW];
    assign req_idx = bus.req_addr[OFFW +: IDXW];
    assign accept  = (state_q == IDLE) && !flush && bus.req_valid;

    // RAM write port, shared by write hits (byte merge) and refills (full line + tag)
    logic [WAYS-1:0]      ram_we;
    logic [BSEL-1:0]      ram_be;
    logic [DATAWIDTH-1:0] ram_wdata;
    logic                 ram_tag_we;
    logic [DATAWIDTH-1:0] way_rdata [WAYS];
    logic [TAGW-1:0]      way_rtag  [WAYS];

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [DATAWIDTH-1:0] data_mem [SETS];
        logic [TAGW-1:0]      tag_mem  [SETS];
        logic [DATAWIDTH-1:0] ram_rdata;
        logic [TAGW-1:0]      ram_rtag;

        // Per-way byte-lane data/tag RAM; the indexed set is read when a request is accepted
        always_ff @(posedge clk) begin
            for (int b = 0; b < BSEL; b++) begin
                if (ram_we[gi] && ram_be[b]) begin
                    data_mem[cur_idx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
            if (ram_we[gi] && ram_tag_we) begin
                tag_mem[cur_idx] <= cur_tag;
            end
            if (accept) begin
                ram_rdata <= data_mem[req_idx];
                ram_rtag  <= tag_mem[req_idx];
            end
        end

        assign way_rdata[gi] = ram_rdata;
        assign way_rtag[gi]  = ram_rtag;
    end

    // Tag compare across valid ways, hit-data mux and lowest invalid way
    logic [WAYS-1:0]      hit_vec;
    logic                 any_hit;
    logic [DATAWIDTH-1:0] hit_data;
    logic                 any_inval;
    logic [WAYW-1:0]      inval_way;

    always_comb begin
        hit_vec   = '0;
        hit_data  = '0;
        any_inval = 1'b0;
        inval_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[cur_idx][w] && (way_rtag[w] == cur_tag);
            hit_data   = hit_data | ({DATAWIDTH{hit_vec[w]}} & way_rdata[w]);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[cur_idx][w]) begin
                any_inval = 1'b1;
                inval_way = WAYW'(w);
            end
        end
    end

    assign any_hit = |hit_vec;

    // Next-state, RAM write control and response/refill outputs
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        bsel_d        = bsel_q;
        wdata_d       = wdata_q;
        victim_d      = victim_q;
        valid_d       = valid_q;
        rr_d          = rr_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_rdata_d   = rsp_rdata_q;
        refill_req_d  = refill_req_q;
        refill_addr_d = refill_addr_q;
        ram_we        = '0;
        ram_be        = '0;
        ram_wdata     = wdata_q;
        ram_tag_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_d[s] = '0;
                    end
                end else if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    we_d    = bus.req_we;
                    bsel_d  = bus.req_bsel;
                    wdata_d = bus.req_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (any_hit) begin
                    rsp_hit_d = 1'b1;
                    if (we_q) begin
                        ram_we = hit_vec;
                        ram_be = bsel_q;
                    end else begin
                        rsp_rdata_d = hit_data;
                    end
                    state_d = RESP;
                end else if (we_q) begin
                    // No write allocation: memory gets the write via the external path
                    rsp_hit_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    if (any_inval) begin
                        victim_d = inval_way;
                    end else begin
                        victim_d = rr_q[cur_idx];
                        if (WAYS > 1) begin
                            rr_d[cur_idx] = rr_q[cur_idx] + 1'b1;
                        end
                    end
                    refill_req_d  = 1'b1;
                    refill_addr_d = addr_q & ~ADDRWIDTH'(BSEL - 1);
                    state_d       = REFILL;
                end
            end
            REFILL: begin
                if (refill_valid) begin
                    ram_we[victim_q]           = 1'b1;
                    ram_be                     = '1;
                    ram_wdata                  = refill_data;
                    ram_tag_we                 = 1'b1;
                    valid_d[cur_idx][victim_q] = 1'b1;
                    rsp_rdata_d                = refill_data;
                    rsp_hit_d                  = 1'b0;
                    refill_req_d               = 1'b0;
                    state_d                    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rsp_valid_d = (state_d == RESP);
    end

    // State, captured request, valid bits, round-robin pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            bsel_q        <= '0;
            wdata_q       <= '0;
            victim_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            refill_req_q  <= 1'b0;
            refill_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            bsel_q        <= bsel_d;
            wdata_q       <= wdata_d;
            victim_q      <= victim_d;
            valid_q       <= valid_d;
            rr_q          <= rr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_rdata_q   <= rsp_rdata_d;
            refill_req_q  <= refill_req_d;
            refill_addr_q <= refill_addr_d;
        end
    end

    // Ready only in IDLE, never while flushing or held in reset
    assign bus.req_ready = rst_n && (state_q == IDLE) && !flush;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign refill_req    = refill_req_q;
    assign refill_addr   = refill_addr_q;
endmodule
